clock_freq_sequencer: RTL and testbench
=======================================

CLOCK_FREQ_SEQUENCER -- requirements
Module: clock_freq_sequencer

Interface
REQ-001 Parameter COUNTER_WIDTH, default 16: width of count_in and result; matches the clock counter being controlled.
REQ-002 Parameter WINDOW_WIDTH, default 16: width of window_cycles.
REQ-003 Parameter CLEAR_CYCLES, default 8: number of clk cycles counter_sync_reset is held; valid range 1 or more.
REQ-004 Parameter SETTLE_CYCLES, default 16: number of clk cycles between enable deassertion and result capture; valid range 1 or more.
REQ-005 Port clk, input, 1: the single clock; every port is in this domain.
REQ-006 Port reset, input, 1: asynchronous, active-high reset.
REQ-007 Port start, input, 1: measurement request, sampled only in IDLE.
REQ-008 Port abort, input, 1: cancels any measurement in progress.
REQ-009 Port continuous, input, 1: when high at the end of DRAIN, a new measurement begins automatically.
REQ-010 Port window_cycles, input, WINDOW_WIDTH: counting window length in clk cycles, latched when start is accepted.
REQ-011 Port counter_sync_reset, output, 1: drives the controlled counter's sync_reset.
REQ-012 Port counter_enable, output, 1: drives the controlled counter's enable.
REQ-013 Port count_in, input, COUNTER_WIDTH: the controlled counter's count, already in the clk domain.
REQ-014 Port busy, output, 1: high when the state is not IDLE.
REQ-015 Port done, output, 1: one-cycle pulse when result updates.
REQ-016 Port result, output, COUNTER_WIDTH: last captured count; held until the next capture.

Function
REQ-017 The FSM states shall be IDLE, CLEAR, RUN and DRAIN.
REQ-018 counter_sync_reset, counter_enable and busy shall be decoded from the registered state only, with no combinational path from inputs:
- counter_sync_reset = (state == CLEAR)
- counter_enable = (state == RUN)
REQ-019 In IDLE, when start=1 and abort=0, the block shall latch window_cycles into window_q and enter CLEAR on the next edge; otherwise it shall stay in IDLE.
REQ-020 CLEAR shall last exactly CLEAR_CYCLES cycles and then go to RUN, or go directly to DRAIN if window_q == 0.
REQ-021 RUN shall last exactly window_q cycles and then go to DRAIN.
REQ-022 DRAIN shall last exactly SETTLE_CYCLES cycles.
REQ-023 On the edge ending DRAIN, the block shall:
- load result with count_in;
- register done=1 for the following single cycle;
- go to CLEAR (re-latching window_cycles) if continuous=1, otherwise go to IDLE.
REQ-024 Phase timers shall be wide enough for max(CLEAR_CYCLES, SETTLE_CYCLES, 2^WINDOW_WIDTH-1), load at phase entry, and never wrap.
REQ-025 start while busy=1 shall be ignored, and window_q shall not change.
REQ-026 abort=1 in any non-IDLE state shall force IDLE on the next edge, with no done pulse and result unchanged.
REQ-027 abort takes priority over start, over continuous, and over the end-of-DRAIN capture; abort in IDLE has no effect.
REQ-028 done and a new start in the same IDLE cycle are legal; the start shall be accepted.

Reset
REQ-029 While reset=1, the block shall asynchronously hold:
- state = IDLE, timers = 0, window_q = 0;
- counter_sync_reset = 0, counter_enable = 0;
- busy = 0, done = 0, result = 0.
REQ-030 Reset asserted mid-measurement shall discard the measurement with no done pulse; operation resumes from IDLE on the first edge after reset deasserts.

Verification
REQ-031 CLEAR_CYCLES=4, SETTLE_CYCLES=8, window_cycles=10, start pulsed in cycle 0 -> required response:
- counter_sync_reset=1 in cycles 1-4;
- counter_enable=1 in cycles 5-14;
- done=1 in cycle 23 with result equal to count_in at cycle 22;
- busy=1 in cycles 1-22.
REQ-032 Same settings with window_cycles=0 -> counter_enable never asserts; done in cycle 13.
REQ-033 Same settings with continuous=1 -> done at cycle 23, counter_sync_reset=1 in cycles 23-26, busy stays 1 throughout; deasserting continuous before the next DRAIN end returns the block to IDLE after the second done.
REQ-034 Same settings with abort in cycle 8 -> IDLE in cycle 9, counter_enable=0 from cycle 9, no done, result unchanged.
REQ-035 Same settings with start re-pulsed in cycles 3 and 12 (busy) and window_cycles changed -> no effect on timing; the window stays 10.
REQ-036 Same settings with reset asserted asynchronously mid-RUN -> all outputs 0 immediately; a start after release gives the full REQ-031 timing.

Source files
------------

// File: rtl/clock_freq_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : clock_freq_sequencer
//  Purpose  : Sequences a gated clock counter through one frequency
//             measurement: clear the counter, enable it for a programmable
//             window of clk cycles, let it settle, then capture its count.
//             An optional continuous mode chains measurements back to back.
//  Revision : 1.0  initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk                 in   single clock; every port is in this domain
//    reset               in   asynchronous, active-high reset
//    start               in   measurement request, sampled only in IDLE
//    abort               in   cancels a measurement in progress
//    continuous          in   restart automatically at the end of DRAIN
//    window_cycles       in   counting window length, latched on start
//    counter_sync_reset  out  clear strobe for the controlled counter
//    counter_enable      out  count enable for the controlled counter
//    count_in            in   controlled counter value (clk domain)
//    busy                out  high whenever the sequencer is not IDLE
//    done                out  one-cycle pulse when result updates
//    result              out  last captured count
// ============================================================================
module clock_freq_sequencer #(
   parameter int COUNTER_WIDTH = 16,
   parameter int WINDOW_WIDTH  = 16,
   parameter int CLEAR_CYCLES  = 8,
   parameter int SETTLE_CYCLES = 16
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     start,
   input  logic                     abort,
   input  logic                     continuous,
   input  logic [WINDOW_WIDTH-1:0]  window_cycles,
   output logic                     counter_sync_reset,
   output logic                     counter_enable,
   input  logic [COUNTER_WIDTH-1:0] count_in,
   output logic                     busy,
   output logic                     done,
   output logic [COUNTER_WIDTH-1:0] result
);

   // Timer must hold the longest phase length of the three phases.
   localparam logic [63:0] c_win_max = (64'd1 << WINDOW_WIDTH) - 64'd1;
   localparam logic [63:0] c_cs_max  = (64'(CLEAR_CYCLES) > 64'(SETTLE_CYCLES)) ?
                                       64'(CLEAR_CYCLES) : 64'(SETTLE_CYCLES);
   localparam logic [63:0] c_max     = (c_cs_max > c_win_max) ? c_cs_max : c_win_max;
   localparam int          c_timer_w = $clog2(c_max + 64'd1);

   // Timers load "length - 1" on phase entry and the phase ends when the
   // timer reads zero, so a phase of N cycles occupies exactly N cycles.
   localparam logic [c_timer_w-1:0] c_one        = c_timer_w'(1);
   localparam logic [c_timer_w-1:0] c_zero       = '0;
   localparam logic [c_timer_w-1:0] c_clr_load   = c_timer_w'(CLEAR_CYCLES - 1);
   localparam logic [c_timer_w-1:0] c_settle_ld  = c_timer_w'(SETTLE_CYCLES - 1);

   localparam logic [1:0] c_st_idle  = 2'd0;
   localparam logic [1:0] c_st_clear = 2'd1;
   localparam logic [1:0] c_st_run   = 2'd2;
   localparam logic [1:0] c_st_drain = 2'd3;

   logic [1:0]               state_q,  state_d;
   logic [c_timer_w-1:0]     timer_q,  timer_d;
   logic [WINDOW_WIDTH-1:0]  window_q, window_d;
   logic [COUNTER_WIDTH-1:0] result_q, result_d;
   logic                     done_q,   done_d;

   logic [c_timer_w-1:0]     w_win_load;
   logic [c_timer_w-1:0]     w_timer_dec;

   assign w_win_load  = c_timer_w'(window_q) - c_one;
   // Saturate at zero so the timer can never wrap.
   assign w_timer_dec = (timer_q != c_zero) ? (timer_q - c_one) : timer_q;

   // ---------------------------------------------------------------- state register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q  <= c_st_idle;
         timer_q  <= '0;
         window_q <= '0;
         result_q <= '0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         timer_q  <= timer_d;
         window_q <= window_d;
         result_q <= result_d;
         done_q   <= done_d;
      end
   end

   // ---------------------------------------------------------------- next state
   always_comb begin
      state_d  = state_q;
      timer_d  = w_timer_dec;
      window_d = window_q;
      result_d = result_q;
      done_d   = 1'b0;

      case (state_q)
         c_st_idle: begin
            if (start && !abort) begin
               state_d  = c_st_clear;
               timer_d  = c_clr_load;
               window_d = window_cycles;
            end
         end
         c_st_clear: begin
            if (timer_q == c_zero) begin
               // A zero-length window skips RUN entirely.
               if (window_q == '0) begin
                  state_d = c_st_drain;
                  timer_d = c_settle_ld;
               end else begin
                  state_d = c_st_run;
                  timer_d = w_win_load;
               end
            end
         end
         c_st_run: begin
            if (timer_q == c_zero) begin
               state_d = c_st_drain;
               timer_d = c_settle_ld;
            end
         end
         c_st_drain: begin
            if (timer_q == c_zero) begin
               result_d = count_in;
               done_d   = 1'b1;
               if (continuous) begin
                  state_d  = c_st_clear;
                  timer_d  = c_clr_load;
                  window_d = window_cycles;
               end else begin
                  state_d = c_st_idle;
                  timer_d = c_zero;
               end
            end
         end
         default: begin
            state_d = c_st_idle;
            timer_d = c_zero;
         end
      endcase

      // Abort overrides everything, including the end-of-DRAIN capture.
      if (abort && (state_q != c_st_idle)) begin
         state_d  = c_st_idle;
         timer_d  = c_zero;
         window_d = window_q;
         result_d = result_q;
         done_d   = 1'b0;
      end
   end

   // ---------------------------------------------------------------- outputs
   always_comb begin
      counter_sync_reset = 1'b0;
      counter_enable     = 1'b0;
      busy               = 1'b0;
      counter_sync_reset = (state_q == c_st_clear);
      counter_enable     = (state_q == c_st_run);
      busy               = (state_q != c_st_idle);
   end

   assign done   = done_q;
   assign result = result_q;

endmodule
`default_nettype wire

// File: tb/tb_clock_freq_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_clock_freq_sequencer
//  Purpose  : Directed self-checking bench for clock_freq_sequencer with
//             CLEAR_CYCLES=4, SETTLE_CYCLES=8. Cycle 0 of each scenario is
//             the cycle in which start is driven high; outputs are sampled
//             1 time unit after each rising edge.
//  Revision : 1.0  initial release
// ============================================================================
module tb_clock_freq_sequencer;

   localparam int CW = 16;
   localparam int WW = 16;

   logic          clk = 1'b0;
   logic          reset = 1'b0;
   logic          start = 1'b0;
   logic          abort = 1'b0;
   logic          continuous = 1'b0;
   logic [WW-1:0] window_cycles = '0;
   logic [CW-1:0] count_in = '0;
   logic          counter_sync_reset;
   logic          counter_enable;
   logic          busy;
   logic          done;
   logic [CW-1:0] result;

   int            n_checks = 0;
   int            n_fail   = 0;
   logic [CW-1:0] exp_result = '0;

   clock_freq_sequencer #(
      .COUNTER_WIDTH (CW),
      .WINDOW_WIDTH  (WW),
      .CLEAR_CYCLES  (4),
      .SETTLE_CYCLES (8)
   ) dut (
      .clk                (clk),
      .reset              (reset),
      .start              (start),
      .abort              (abort),
      .continuous         (continuous),
      .window_cycles      (window_cycles),
      .counter_sync_reset (counter_sync_reset),
      .counter_enable     (counter_enable),
      .count_in           (count_in),
      .busy               (busy),
      .done               (done),
      .result             (result)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic chk_outputs(input string sc, input int c, input bit e_scr, input bit e_en,
                              input bit e_busy, input bit e_done, input logic [CW-1:0] e_res);
      chk($sformatf("%s c%0d sync_reset", sc, c), 32'(counter_sync_reset), 32'(e_scr));
      chk($sformatf("%s c%0d enable", sc, c),     32'(counter_enable),     32'(e_en));
      chk($sformatf("%s c%0d busy", sc, c),       32'(busy),               32'(e_busy));
      chk($sformatf("%s c%0d done", sc, c),       32'(done),               32'(e_done));
      chk($sformatf("%s c%0d result", sc, c),     32'(result),             32'(e_res));
   endtask

   // One non-continuous measurement with window w, start in cycle 0.
   // Expected timeline: CLEAR 1..4, RUN 5..4+w, DRAIN 5+w..12+w, done 13+w.
   task automatic measure(input string sc, input int w, input int last, input int abort_at,
                          input bit repulse, input logic [CW-1:0] base);
      logic [CW-1:0] old_res;
      bit            ab;
      bit            cap;
      old_res = exp_result;
      cap     = 1'b0;
      for (int c = 0; c <= last; c++) begin
         start         = (c == 0) || (repulse && (c == 3 || c == 12));
         window_cycles = (repulse && c > 0) ? 16'd5 : 16'(w);
         abort         = (c == abort_at);
         continuous    = 1'b0;
         count_in      = base + 16'(c);
         ab = (abort_at >= 0) && (c > abort_at);
         if (!ab && c >= 13 + w) cap = 1'b1;
         chk_outputs(sc, c,
                     !ab && c >= 1 && c <= 4,
                     !ab && c >= 5 && c <= 4 + w,
                     !ab && c >= 1 && c <= 12 + w,
                     !ab && c == 13 + w,
                     cap ? base + 16'(12 + w) : old_res);
         @(posedge clk); #1;
      end
      start = 1'b0;
      abort = 1'b0;
      if (cap) exp_result = base + 16'(12 + w);
   endtask

   initial begin
      // ---- reset state
      #2 reset = 1'b1;
      #1;
      chk_outputs("reset", 0, 1'b0, 1'b0, 1'b0, 1'b0, '0);
      @(posedge clk); #1;
      @(posedge clk); #1;
      reset = 1'b0;
      @(posedge clk); #1;
      chk_outputs("idle", 0, 1'b0, 1'b0, 1'b0, 1'b0, '0);

      // ---- basic window of 10, idle tail after done
      measure("basic", 10, 26, -1, 1'b0, 16'h1000);

      // ---- zero-length window skips RUN
      measure("win0", 0, 16, -1, 1'b0, 16'h2000);

      // ---- continuous mode, then done+start in the same IDLE cycle
      for (int c = 0; c <= 60; c++) begin
         logic [CW-1:0] er;
         start         = (c == 0) || (c == 45);
         window_cycles = (c < 45) ? 16'd10 : 16'd0;
         continuous    = (c < 30);
         count_in      = 16'h3000 + 16'(c);
         if (c < 23)      er = exp_result;
         else if (c < 45) er = 16'h3000 + 16'd22;
         else if (c < 58) er = 16'h3000 + 16'd44;
         else             er = 16'h3000 + 16'd57;
         chk_outputs("cont", c,
                     (c >= 1 && c <= 4) || (c >= 23 && c <= 26) || (c >= 46 && c <= 49),
                     (c >= 5 && c <= 14) || (c >= 27 && c <= 36),
                     (c >= 1 && c <= 44) || (c >= 46 && c <= 57),
                     (c == 23) || (c == 45) || (c == 58),
                     er);
         @(posedge clk); #1;
      end
      start      = 1'b0;
      continuous = 1'b0;
      exp_result = 16'h3000 + 16'd57;

      // ---- abort during RUN: no done, result held
      measure("abort", 10, 30, 8, 1'b0, 16'h4000);

      // ---- start re-pulsed while busy with a different window: ignored
      measure("repulse", 10, 26, -1, 1'b1, 16'h5000);

      // ---- asynchronous reset mid-RUN
      measure("prerst", 10, 8, -1, 1'b0, 16'h6000);
      #2 reset = 1'b1;
      #1;
      chk_outputs("midrst", 9, 1'b0, 1'b0, 1'b0, 1'b0, '0);
      @(posedge clk); #1;
      chk_outputs("midrst", 10, 1'b0, 1'b0, 1'b0, 1'b0, '0);
      reset = 1'b0;
      exp_result = '0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      measure("postrst", 10, 26, -1, 1'b0, 16'h7000);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
